// File: rtl/top_corr_pkg.sv
// Shared widths, level table and matched-filter template for the PAM pulse analyser.
// No ports. Optional feature macro used by top_corr: CORR_PHASE_EN.
package top_corr_pkg;

    localparam int SAMPLE_W     = 32;
    localparam int COEF_W       = 40;
    localparam int TAPS         = 32;
    localparam int PULSE_LEN    = 32;
    localparam int PULSE_PERIOD = 20000;
    localparam int PROD_W       = SAMPLE_W + COEF_W;
    localparam int CORR_W       = SAMPLE_W + COEF_W + $clog2(TAPS);
    localparam int PERIOD_W     = 21;
    localparam int PHASE_W      = 10;
    localparam int GEN_W        = $clog2(PULSE_PERIOD);
    localparam int NUM_LEVELS   = 4;
    localparam int XW           = CORR_W + 3;

    localparam logic signed [CORR_W-1:0] DET_THR = 77'sd16384000;

    typedef logic signed [SAMPLE_W-1:0] level_arr_t [NUM_LEVELS];
    localparam level_arr_t LEVEL = '{32'sd1000, 32'sd2000, 32'sd3000, 32'sd4000};

    typedef logic signed [COEF_W-1:0] coef_arr_t [TAPS];
    localparam coef_arr_t COEF = '{default: 40'sd1024};

    typedef enum logic [1:0] {
        DET_IDLE,
        DET_ARMED,
        DET_HOLD
    } det_state_e;

endpackage

// File: rtl/pam_pulse_gen.sv
// Periodic amplitude-modulated rectangular pulse generator.
// Ports: clk, rst_n (async active-low), sample (signed, LEVEL[idx] for the first
// PULSE_LEN cycles of every PULSE_PERIOD, 0 otherwise; idx steps on each wrap).
module pam_pulse_gen
    import top_corr_pkg::*;
(
    input  logic                       clk,
    input  logic                       rst_n,
    output logic signed [SAMPLE_W-1:0] sample
);

    logic [GEN_W-1:0] gen_cnt_q, gen_cnt_d;
    logic [1:0]       idx_q, idx_d;
    logic             wrap;

    always_comb begin
        wrap      = (gen_cnt_q == GEN_W'(PULSE_PERIOD - 1));
        gen_cnt_d = wrap ? '0 : gen_cnt_q + 1'b1;
        idx_d     = wrap ? idx_q + 1'b1 : idx_q;
        sample    = (gen_cnt_q < GEN_W'(PULSE_LEN)) ? LEVEL[idx_q] : '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gen_cnt_q <= '0;
            idx_q     <= '0;
        end else begin
            gen_cnt_q <= gen_cnt_d;
            idx_q     <= idx_d;
        end
    end

endmodule

// File: rtl/top_corr.sv
// PAM pulse analyser: generator, 32-tap matched filter, peak/period/phase measurement.
// Ports: clk, rst_n (async active-low), corr_factor (registered correlation sum),
// period (cycles between last two peaks), time_point (1-cycle peak pulse),
// phase_time (peak to 0.6*peak decay in cycles), phase_mark (high during decay).
// Macro CORR_PHASE_EN enables the phase measurement; otherwise phase outputs are 0.
//
// Peak detector states:
//   state     | meaning
//   DET_IDLE  | corr_factor at or below threshold, waiting for a pulse
//   DET_ARMED | above threshold, looking for the first falling sample
//   DET_HOLD  | peak reported, waiting for corr_factor to fall back below threshold
module top_corr
    import top_corr_pkg::*;
(
    input  logic                     clk,
    input  logic                     rst_n,
    output logic signed [CORR_W-1:0] corr_factor,
    output logic [PERIOD_W-1:0]      period,
    output logic                     time_point,
    output logic [PHASE_W-1:0]       phase_time,
    output logic                     phase_mark
);

    localparam logic [PERIOD_W-1:0] PERIOD_MAX = '1;

    logic signed [SAMPLE_W-1:0] sample;
    logic signed [SAMPLE_W-1:0] taps_q [TAPS];
    logic signed [SAMPLE_W-1:0] taps_d [TAPS];
    logic signed [CORR_W-1:0]   corr_q, corr_d, prev_q;
    logic signed [PROD_W-1:0]   prod;
    det_state_e                 state_q, state_d;
    logic                       tp;
    logic [PERIOD_W-1:0]        per_cnt_q, per_cnt_d, period_q, period_d;
    logic                       seen_q, seen_d;

    pam_pulse_gen u_gen (
        .clk    (clk),
        .rst_n  (rst_n),
        .sample (sample)
    );

    always_comb begin
        taps_d[0] = sample;
        for (int i = 1; i < TAPS; i++) taps_d[i] = taps_q[i-1];
        corr_d = '0;
        prod   = '0;
        for (int i = 0; i < TAPS; i++) begin
            prod   = PROD_W'(taps_q[i]) * PROD_W'(COEF[i]);
            corr_d = corr_d + CORR_W'(prod);
        end
    end

    always_comb begin
        state_d = state_q;
        tp      = 1'b0;
        case (state_q)
            DET_IDLE:  if (corr_q > DET_THR) state_d = DET_ARMED;
            DET_ARMED: if (corr_q < prev_q) begin
                tp      = 1'b1;
                state_d = DET_HOLD;
            end
            DET_HOLD:  if (corr_q <= DET_THR) state_d = DET_IDLE;
            default:   state_d = DET_IDLE;
        endcase
    end

    always_comb begin
        per_cnt_d = (per_cnt_q == PERIOD_MAX) ? PERIOD_MAX : per_cnt_q + 1'b1;
        period_d  = period_q;
        seen_d    = seen_q | tp;
        if (tp) begin
            per_cnt_d = '0;
            // The very first peak has no predecessor to measure against.
            if (!seen_q)                      period_d = '0;
            else if (per_cnt_q == PERIOD_MAX) period_d = PERIOD_MAX;
            else                              period_d = per_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < TAPS; i++) taps_q[i] <= '0;
            corr_q    <= '0;
            prev_q    <= '0;
            state_q   <= DET_IDLE;
            per_cnt_q <= '0;
            period_q  <= '0;
            seen_q    <= 1'b0;
        end else begin
            for (int i = 0; i < TAPS; i++) taps_q[i] <= taps_d[i];
            corr_q    <= corr_d;
            prev_q    <= corr_q;
            state_q   <= state_d;
            per_cnt_q <= per_cnt_d;
            period_q  <= period_d;
            seen_q    <= seen_d;
        end
    end

    assign corr_factor = corr_q;
    assign period      = period_q;
    assign time_point  = tp;

`ifdef CORR_PHASE_EN
    logic signed [CORR_W-1:0] pk_q, pk_d;
    logic                     phase_q, phase_d;
    logic [PHASE_W-1:0]       phcnt_q, phcnt_d, phase_time_q, phase_time_d;
    logic signed [XW-1:0]     corr5, pk3;
    logic                     cross;

    always_comb begin
        corr5        = XW'(corr_q) * XW'(5);
        pk3          = XW'(pk_q) * XW'(3);
        cross        = (corr5 <= pk3);
        pk_d         = pk_q;
        phase_d      = phase_q;
        phcnt_d      = phcnt_q;
        phase_time_d = phase_time_q;
        if (tp) begin
            if (phase_q) phase_time_d = phcnt_q;
            pk_d    = prev_q;
            phase_d = 1'b1;
            // The time_point cycle itself counts as 1, so the register resumes at 2.
            phcnt_d = PHASE_W'(2);
        end else if (phase_q) begin
            if (cross) begin
                phase_time_d = phcnt_q;
                phase_d      = 1'b0;
            end else if (phcnt_q != '1) begin
                phcnt_d = phcnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pk_q         <= '0;
            phase_q      <= 1'b0;
            phcnt_q      <= '0;
            phase_time_q <= '0;
        end else begin
            pk_q         <= pk_d;
            phase_q      <= phase_d;
            phcnt_q      <= phcnt_d;
            phase_time_q <= phase_time_d;
        end
    end

    assign phase_mark = phase_q | tp;
    assign phase_time = phase_time_q;
`else
    assign phase_mark = 1'b0;
    assign phase_time = '0;
`endif

endmodule

// File: tb/tb_top_corr.sv
`timescale 1ns/1ps
module tb_top_corr;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic signed [76:0] corr_factor;
    logic [20:0]        period;
    logic               time_point;
    logic [9:0]         phase_time;
    logic               phase_mark;

    top_corr dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .corr_factor (corr_factor),
        .period      (period),
        .time_point  (time_point),
        .phase_time  (phase_time),
        .phase_mark  (phase_mark)
    );

    always #5 clk = ~clk;

    typedef struct {
        int                 period;
        logic signed [76:0] peak;
    } exp_t;

    exp_t               exp_q[$];
    int                 checks = 0;
    int                 errors = 0;
    int                 tp_count = 0;
    logic signed [76:0] prev_corr = '0;
    logic signed [76:0] max_corr = '0;
    logic               per_pending = 1'b0;
    int                 per_exp = 0;
    int                 ph_len = 0;
    logic               ph_last = 1'b0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic push(input int p, input logic signed [76:0] pk);
        exp_t e;
        e.period = p;
        e.peak   = pk;
        exp_q.push_back(e);
    endtask

    task automatic wait_tp(input int n, input int budget, input string name);
        int c = 0;
        while (tp_count < n && c < budget) begin
            @(negedge clk); #1;
            c++;
        end
        chk(name, 128'(tp_count >= n), 128'd1);
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_corr"}, corr_factor, 0);
        chk({tag, "_period"}, period, 0);
        chk({tag, "_time_point"}, time_point, 0);
        chk({tag, "_phase_time"}, phase_time, 0);
        chk({tag, "_phase_mark"}, phase_mark, 0);
    endtask

    // Monitor / scoreboard
    always @(negedge clk) begin
        exp_t rec;
        if (!rst_n) begin
            prev_corr   = '0;
            per_pending = 1'b0;
            ph_len      = 0;
            ph_last     = 1'b0;
        end else begin
            if (per_pending) begin
                chk("period", period, 128'(per_exp));
                per_pending = 1'b0;
            end
            if (time_point) begin
                tp_count++;
                if (exp_q.size() == 0) begin
                    chk("spurious_time_point", 1, 0);
                end else begin
                    rec = exp_q.pop_front();
                    chk("peak_value", prev_corr, rec.peak);
                    chk("post_peak_corr", corr_factor, rec.peak / 32 * 31);
                    per_pending = 1'b1;
                    per_exp     = rec.period;
`ifdef CORR_PHASE_EN
                    chk("phase_mark_at_tp", phase_mark, 1);
`else
                    chk("phase_mark_off", phase_mark, 0);
                    chk("phase_time_off", phase_time, 0);
`endif
                end
            end
`ifdef CORR_PHASE_EN
            if (phase_mark) begin
                ph_len++;
            end else if (ph_last) begin
                chk("phase_mark_len", 128'(ph_len), 13);
                chk("phase_time", phase_time, 13);
                ph_len = 0;
            end
            ph_last = phase_mark;
`endif
            if (corr_factor > max_corr) max_corr = corr_factor;
            prev_corr = corr_factor;
        end
    end

    initial begin
        int lat;
        rst_n = 1'b0;
        repeat (10) @(negedge clk);
        #1;
        chk_zero("reset");

        push(0,     77'sd32768000);
        push(20000, 77'sd65536000);
        push(20000, 77'sd98304000);
        push(20000, 77'sd131072000);
        push(20000, 77'sd32768000);

        @(negedge clk);
        rst_n = 1'b1;
        lat = 0;
        while (tp_count < 1 && lat < 60) begin
            @(negedge clk); #1;
            lat++;
        end
        chk("first_tp_latency_le_40", 128'(lat <= 40), 1);

        wait_tp(4, 61000, "three_more_pulses");
        wait_tp(5, 20100, "fifth_pulse");

        // Abort mid-decay: the fifth pulse is still decaying.
        repeat (3) @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk_zero("mid_decay_reset");
        repeat (10) @(negedge clk);
        push(0, 77'sd32768000);
        rst_n = 1'b1;
        lat = 0;
        while (tp_count < 6 && lat < 60) begin
            @(negedge clk); #1;
            lat++;
        end
        chk("tp_after_reset_le_40", 128'(lat <= 40), 1);
        repeat (30) @(negedge clk);
        #1;

        chk("max_corr", max_corr, 77'sd131072000);
        chk("scoreboard_drained", 128'(exp_q.size()), 0);
        chk("tp_total", 128'(tp_count), 6);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
